// File: rtl/fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe_ctrl
// Brief    : PC, IF/ID register and ID/EXE control half driven by hazard unit.
//            Optional perf counters enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_Write,
  input  logic              IF_ID_Write,
  input  logic              Stall,
  input  logic              PC_Src,
  input  logic [31:0]       Branch_Target,
  input  logic              Jump,
  input  logic              JmpandLink,
  input  logic [31:0]       Jump_Target,
  input  logic              isJr,
  input  logic [31:0]       Jr_Target,
  input  logic [31:0]       Instr_In,
  input  logic [CTRL_W-1:0] ID_Ctrl_In,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count,
`endif
  output logic [31:0]       PC,
  output logic [31:0]       IF_ID_Instr,
  output logic [31:0]       IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic [CTRL_W-1:0] ID_EXE_Ctrl,
  output logic              ID_EXE_Valid
);

  logic [31:0]       r_pc;
  logic [31:0]       r_if_instr;
  logic [31:0]       r_if_pc4;
  logic              r_if_valid;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_ex_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_flush;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = PC_Src | Jump | JmpandLink | isJr;
  // A redirect only squashes the fetched slot when the PC actually moves.
  assign w_flush    = w_redirect & PC_Write;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (PC_Src)                  w_next_pc = Branch_Target;
    else if (Jump | JmpandLink)  w_next_pc = Jump_Target;
    else if (isJr)               w_next_pc = Jr_Target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_if_instr <= NOP_INSTR;
      r_if_pc4   <= 32'd0;
      r_if_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      if (PC_Write) r_pc <= w_next_pc;

      if (w_flush) begin
        r_if_instr <= NOP_INSTR;
        r_if_pc4   <= 32'd0;
        r_if_valid <= 1'b0;
      end else if (IF_ID_Write) begin
        r_if_instr <= Instr_In;
        r_if_pc4   <= w_pc_plus4;
        r_if_valid <= 1'b1;
      end

      if (Stall) begin
        r_ex_ctrl  <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_ctrl  <= ID_Ctrl_In;
        r_ex_valid <= r_if_valid;
      end
    end
  end

  assign PC            = r_pc;
  assign IF_ID_Instr   = r_if_instr;
  assign IF_ID_PCPlus4 = r_if_pc4;
  assign IF_ID_Valid   = r_if_valid;
  assign ID_EXE_Ctrl   = r_ex_ctrl;
  assign ID_EXE_Valid  = r_ex_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (Stall && !PC_Write && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pipe_ctrl
// Brief    : Directed plus randomized bench with a behavioural pipeline model.
// Revision : 1.0
// ============================================================================
module tb_fetch_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_Write = 1'b0, IF_ID_Write = 1'b0, Stall = 1'b0;
  logic        PC_Src = 1'b0, Jump = 1'b0, JmpandLink = 1'b0, isJr = 1'b0;
  logic [31:0] Branch_Target = '0, Jump_Target = '0, Jr_Target = '0, Instr_In = '0;
  logic [15:0] ID_Ctrl_In = '0;
  logic [31:0] PC, IF_ID_Instr, IF_ID_PCPlus4;
  logic        IF_ID_Valid, ID_EXE_Valid;
  logic [15:0] ID_EXE_Ctrl;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_evalid;
  logic [15:0] m_ctrl;
  logic [31:0] m_scnt, m_fcnt;

  fetch_pipe_ctrl #(
    .RESET_PC(32'h0000_0000), .CTRL_W(16), .NOP_INSTR(32'h0000_0000)
  ) u_dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Stall(Stall), .PC_Src(PC_Src), .Branch_Target(Branch_Target), .Jump(Jump),
    .JmpandLink(JmpandLink), .Jump_Target(Jump_Target), .isJr(isJr),
    .Jr_Target(Jr_Target), .Instr_In(Instr_In), .ID_Ctrl_In(ID_Ctrl_In),
`ifdef FETCH_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .PC(PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .ID_EXE_Ctrl(ID_EXE_Ctrl), .ID_EXE_Valid(ID_EXE_Valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] pc4, tgt;
    logic        redir, old_valid;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_ctrl = 16'h0; m_evalid = 1'b0; m_scnt = 32'h0; m_fcnt = 32'h0;
      return;
    end
    pc4   = m_pc + 32'd4;
    redir = PC_Src | Jump | JmpandLink | isJr;
    tgt   = PC_Src ? Branch_Target : (Jump | JmpandLink) ? Jump_Target : isJr ? Jr_Target : pc4;
    old_valid = m_valid;
    m_ctrl   = Stall ? 16'h0 : ID_Ctrl_In;
    m_evalid = Stall ? 1'b0 : old_valid;
    if (PC_Write && redir) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end else if (IF_ID_Write) begin
      m_instr = Instr_In; m_pc4 = pc4; m_valid = 1'b1;
    end
    if (Stall && !PC_Write && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (PC_Write) m_pc = tgt;
  endtask

  task automatic check_all();
    check_val("pc", PC, m_pc);
    check_val("if_instr", IF_ID_Instr, m_instr);
    check_val("if_pc4", IF_ID_PCPlus4, m_pc4);
    check_val("if_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
    check_val("ex_ctrl", {16'd0, ID_EXE_Ctrl}, {16'd0, m_ctrl});
    check_val("ex_valid", {31'd0, ID_EXE_Valid}, {31'd0, m_evalid});
`ifdef FETCH_PERF_CNT_EN
    check_val("stall_cnt", stall_count, m_scnt);
    check_val("flush_cnt", flush_count, m_fcnt);
`endif
  endtask

  // Apply one set of inputs, clock it, advance the model and compare.
  task automatic step(input logic rst, input logic [2:0] hz, input logic [3:0] redir,
                      input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt,
                      input logic [31:0] ins, input logic [15:0] ctl);
    reset = rst;
    {PC_Write, IF_ID_Write, Stall} = hz;
    {PC_Src, Jump, JmpandLink, isJr} = redir;
    Branch_Target = bt; Jump_Target = jt; Jr_Target = jrt;
    Instr_In = ins; ID_Ctrl_In = ctl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [2:0]  hz;
    logic [3:0]  rd;
    step(1'b1, 3'b000, 4'b0000, 0, 0, 0, 0, 16'h0);
    check_val("rst_pc", PC, 32'h0);

    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h11, 16'h0A0A);
    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h22, 16'h0B0B);
    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h33, 16'h0C0C);
    check_val("seq_pc", PC, 32'd12);
    check_val("seq_instr", IF_ID_Instr, 32'h33);
    check_val("seq_pc4", IF_ID_PCPlus4, 32'd12);
    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h44, 16'h0D0D);
    check_val("pc_0x10", PC, 32'h10);

    step(1'b0, 3'b001, 4'b0000, 0, 0, 0, 32'h55, 16'h1234);
    check_val("lu_pc", PC, 32'h10);
    check_val("lu_instr", IF_ID_Instr, 32'h44);
    check_val("lu_ctrl", {16'd0, ID_EXE_Ctrl}, 32'h0);
    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h55, 16'h1234);
    check_val("lu_resume", PC, 32'h14);

    step(1'b0, 3'b101, 4'b1100, 32'h100, 32'h200, 0, 32'h66, 16'h5555);
    check_val("br_pc", PC, 32'h100);
    check_val("br_valid", {31'd0, IF_ID_Valid}, 32'h0);
    check_val("br_exv", {31'd0, ID_EXE_Valid}, 32'h0);

    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'h77, 16'h1111);
    step(1'b0, 3'b000, 4'b0001, 0, 0, 32'h300, 32'h88, 16'h2222);
    check_val("jr_hold_pc", PC, 32'h104);
    check_val("jr_hold_if", IF_ID_Instr, 32'h77);

    step(1'b0, 3'b100, 4'b0100, 0, 32'hFFFF_FFFC, 0, 32'h99, 16'h0);
    step(1'b0, 3'b110, 4'b0000, 0, 0, 0, 32'hAA, 16'h0);
    check_val("wrap_pc", PC, 32'h0);
    check_val("wrap_pc4", IF_ID_PCPlus4, 32'h0);

    step(1'b0, 3'b001, 4'b0000, 0, 0, 0, 32'hBB, 16'h3333);
    step(1'b1, 3'b001, 4'b0000, 0, 0, 0, 32'hBB, 16'h3333);
    check_val("rst_stall_pc", PC, 32'h0);
    check_val("rst_stall_v", {31'd0, IF_ID_Valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_val("rst_stall_cnt", stall_count, 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       hz = 3'b001;
        1:       hz = 3'b101;
        2:       hz = 3'($urandom);
        default: hz = 3'b110;
      endcase
      rd = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 63) == 0), hz, rd,
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           $urandom, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pipe_ctrl.md
# fetch_pipe_ctrl

Fetch-side pipeline control block that executes the hazard unit's control signals. It owns the program counter, the IF/ID pipeline register and the control half of the ID/EXE register. It applies PC_Write, IF_ID_Write and Stall each cycle, redirects fetch on branch/jump/jr, flushes the wrong-path instruction and inserts control bubbles. It sits between instruction memory, the decoder and the hazard detection unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 16, width of the decoded control word carried into ID/EXE
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- PC_Write  in  1  from hazard unit; 0 holds PC
- IF_ID_Write  in  1  from hazard unit; 0 holds IF/ID (unless flushing)
- Stall  in  1  from hazard unit; 1 loads a bubble into ID/EXE control
- PC_Src  in  1  taken branch resolved in ID
- Branch_Target  in  32  branch destination
- Jump  in  1  j
- JmpandLink  in  1  jal (same redirect as Jump)
- Jump_Target  in  32  j/jal destination
- isJr  in  1  jr
- Jr_Target  in  32  register-sourced destination
- Instr_In  in  32  instruction memory read data for current PC (combinational memory)
- ID_Ctrl_In  in  CTRL_W  decoder control word for IF/ID instruction
- PC  out  32  current fetch address
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction
- IF_ID_Valid  out  1  0 = bubble/flushed slot
- ID_EXE_Ctrl  out  CTRL_W  registered control word
- ID_EXE_Valid  out  1  0 = bubble in EXE

## Operation
- next_pc priority: PC_Src → Branch_Target; else Jump|JmpandLink → Jump_Target; else isJr → Jr_Target; else PC+4.
- PC+4 is 32-bit modulo arithmetic; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- redirect = PC_Src | Jump | JmpandLink | isJr.
- PC: if PC_Write then PC <= next_pc, else hold. Redirect with PC_Write=0 is ignored (PC holds).
- IF/ID, in priority order:
  - redirect & PC_Write: flush. Instr <= NOP_INSTR, PCPlus4 <= 0, Valid <= 0.
  - else IF_ID_Write: Instr <= Instr_In, PCPlus4 <= PC+4, Valid <= 1.
  - else hold all three fields.
  - Flush overrides IF_ID_Write=0, which the hazard unit asserts during redirects.
- ID/EXE control:
  - Stall=1: Ctrl <= 0, Valid <= 0.
  - else Ctrl <= ID_Ctrl_In, Valid <= IF_ID_Valid.
- Hazard-unit encodings:
  - (1,1,0) = normal advance.
  - (PC_Write=0, IF_ID_Write=0, Stall=1) = load-use: PC and IF/ID hold, one bubble.
  - (1,0,1) with PC_Src = branch: redirect, flush and bubble.
  - (1,0,0) with a jump = redirect and flush, no bubble.

## Timing
- All outputs are registered and update on rising clk. Instr_In is sampled in the same cycle that PC is presented.
- Reset values: PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, ID_EXE_Ctrl=0, ID_EXE_Valid=0.
- First valid IF/ID instruction appears on the first edge after reset deasserts.
- Redirect penalty: the target is in PC 1 cycle after the redirect edge; its instruction is in IF/ID 2 cycles after.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge; no pending state survives.
- Stall and redirect in the same cycle: both take effect.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two 32-bit outputs, stall_count and flush_count.
  - stall_count increments on each edge with Stall=1 and PC_Write=0.
  - flush_count increments on each flush edge.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then 3 edges with (1,1,0) and Instr_In = 0x11, 0x22, 0x33:
  - PC = 0, 4, 8, 12.
  - IF_ID_Instr = 0x11, 0x22, 0x33; IF_ID_PCPlus4 = 4, 8, 12; Valid = 1.
- Load-use: PC=0x10, one edge with (0,0,1):
  - PC stays 0x10 and IF/ID holds.
  - ID_EXE_Ctrl=0, ID_EXE_Valid=0.
  - Next edge with (1,1,0) resumes at 0x14.
- Branch: PC_Src=1, Branch_Target=0x100, Jump=1, Jump_Target=0x200, (1,0,1):
  - PC=0x100 (branch has priority).
  - IF_ID_Valid=0, IF_ID_Instr=NOP_INSTR, ID_EXE_Valid=0.
- jr with PC_Write=0: PC holds and IF/ID holds; no flush.
- Wrap: PC=0xFFFF_FFFC, normal edge → PC=0x0000_0000, IF_ID_PCPlus4=0.
- Reset asserted during a load-use stall: all outputs return to reset values on that edge. With FETCH_PERF_CNT_EN defined, stall_count=0.
